memory_ram_access_ctrl: RTL and testbench

//  Sequences and shares the home-memory directory-state RAM (6b) and data RAM (128b) between two requesters:

---
 rtl/memory_ram_access_ctrl.sv | 179 +++++++++++++++++
 tb/tb_memory_ram_access_ctrl.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_ram_access_ctrl.sv
// Round-robin sequencer sharing the directory-state / data RAM pair between the local core and the ring.
// Build option: define MEM_ARB_RMW_EN to make op 11 an atomic read-modify-write of the state (else it reads).
module memory_ram_access_ctrl #(
    parameter int ST_W   = 6,
    parameter int DATA_W = 128,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              loc_req,
    input  logic [1:0]        loc_op,
    input  logic [ADDR_W-1:0] loc_addr,
    input  logic [ST_W-1:0]   loc_state,
    input  logic [DATA_W-1:0] loc_data,
    output logic              loc_gnt,
    output logic              loc_done,
    input  logic              ic_req,
    input  logic [1:0]        ic_op,
    input  logic [ADDR_W-1:0] ic_addr,
    input  logic [ST_W-1:0]   ic_state,
    input  logic [DATA_W-1:0] ic_data,
    output logic              ic_gnt,
    output logic              ic_done,
    output logic [ST_W-1:0]   rsp_state,
    output logic [DATA_W-1:0] rsp_data,
    output logic              state_we_out,
    output logic              state_re_out,
    output logic              data_we_out,
    output logic              data_re_out,
    output logic [ADDR_W-1:0] addr_out,
    output logic [ST_W-1:0]   state_wr,
    output logic [DATA_W-1:0] data_wr,
    input  logic [ST_W-1:0]   ram_state_in,
    input  logic [DATA_W-1:0] ram_data_in
);

    // state | meaning
    // IDLE  | arbitrate, grant winner, latch its request
    // RD    | read strobes to both RAMs
    // CAP   | RAM dout valid, captured into rsp regs
    // WR    | state (and for WR_ALL data) write strobes
    typedef enum logic [1:0] {S_IDLE, S_RD, S_CAP, S_WR} state_e;

    localparam logic [1:0] OP_RD     = 2'b00;
    localparam logic [1:0] OP_WR_ST  = 2'b01;
    localparam logic [1:0] OP_WR_ALL = 2'b10;
    localparam logic [1:0] OP_RMW    = 2'b11;

`ifdef MEM_ARB_RMW_EN
    localparam bit RMW_EN = 1'b1;
`else
    localparam bit RMW_EN = 1'b0;
`endif

    state_e              state_q, state_d;
    logic                ptr_q, ptr_d;      // 1: ic wins a tie
    logic                owner_q, owner_d;  // 1: ic owns the op in flight
    logic [1:0]          op_q, op_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ST_W-1:0]     st_q, st_d;
    logic [DATA_W-1:0]   dt_q, dt_d;
    logic [ST_W-1:0]     rsp_st_q, rsp_st_d;
    logic [DATA_W-1:0]   rsp_dt_q, rsp_dt_d;
    logic                loc_done_q, loc_done_d;
    logic                ic_done_q, ic_done_d;

    logic                win_ic;
    logic [1:0]          sel_op;

    assign win_ic = ic_req & (~loc_req | ptr_q);
    assign sel_op = win_ic ? ic_op : loc_op;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        owner_d      = owner_q;
        op_d         = op_q;
        addr_d       = addr_q;
        st_d         = st_q;
        dt_d         = dt_q;
        rsp_st_d     = rsp_st_q;
        rsp_dt_d     = rsp_dt_q;
        loc_done_d   = 1'b0;
        ic_done_d    = 1'b0;
        loc_gnt      = 1'b0;
        ic_gnt       = 1'b0;
        state_we_out = 1'b0;
        state_re_out = 1'b0;
        data_we_out  = 1'b0;
        data_re_out  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (loc_req || ic_req) begin
                    owner_d = win_ic;
                    if (loc_req && ic_req) ptr_d = ~win_ic;
                    op_d    = sel_op;
                    addr_d  = win_ic ? ic_addr  : loc_addr;
                    st_d    = win_ic ? ic_state : loc_state;
                    dt_d    = win_ic ? ic_data  : loc_data;
                    loc_gnt = ~win_ic;
                    ic_gnt  = win_ic;
                    state_d = (sel_op == OP_WR_ST || sel_op == OP_WR_ALL) ? S_WR : S_RD;
                end
            end
            S_RD: begin
                state_re_out = 1'b1;
                data_re_out  = 1'b1;
                state_d      = S_CAP;
            end
            S_CAP: begin
                rsp_st_d = ram_state_in;
                rsp_dt_d = ram_data_in;
                if (RMW_EN && op_q == OP_RMW) begin
                    state_d = S_WR;
                end else begin
                    loc_done_d = ~owner_q;
                    ic_done_d  = owner_q;
                    state_d    = S_IDLE;
                end
            end
            S_WR: begin
                state_we_out = 1'b1;
                data_we_out  = (op_q == OP_WR_ALL);
                loc_done_d   = ~owner_q;
                ic_done_d    = owner_q;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Synchronous reset takes effect at the next edge; suppress grants and strobes meanwhile.
        if (rst) begin
            loc_gnt      = 1'b0;
            ic_gnt       = 1'b0;
            state_we_out = 1'b0;
            state_re_out = 1'b0;
            data_we_out  = 1'b0;
            data_re_out  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= 1'b1;
            owner_q    <= 1'b0;
            op_q       <= OP_RD;
            addr_q     <= '0;
            st_q       <= '0;
            dt_q       <= '0;
            rsp_st_q   <= '0;
            rsp_dt_q   <= '0;
            loc_done_q <= 1'b0;
            ic_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            st_q       <= st_d;
            dt_q       <= dt_d;
            rsp_st_q   <= rsp_st_d;
            rsp_dt_q   <= rsp_dt_d;
            loc_done_q <= loc_done_d;
            ic_done_q  <= ic_done_d;
        end
    end

    assign loc_done  = loc_done_q;
    assign ic_done   = ic_done_q;
    assign rsp_state = rsp_st_q;
    assign rsp_data  = rsp_dt_q;
    assign addr_out  = addr_q;
    assign state_wr  = st_q;
    assign data_wr   = dt_q;

endmodule

// File: tb/tb_memory_ram_access_ctrl.sv
// Bench for memory_ram_access_ctrl: behavioural RAM pair plus a transaction-level model of arbitration,
// latency and RAM contents; honours MEM_ARB_RMW_EN the same way as the design build.
module tb_memory_ram_access_ctrl;

`ifdef MEM_ARB_RMW_EN
    localparam bit RMW_ON = 1'b1;
`else
    localparam bit RMW_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic loc_req, ic_req;
    logic [1:0] loc_op, ic_op;
    logic [31:0] loc_addr, ic_addr;
    logic [5:0] loc_state, ic_state;
    logic [127:0] loc_data, ic_data;
    logic loc_gnt, loc_done, ic_gnt, ic_done;
    logic [5:0] rsp_state;
    logic [127:0] rsp_data;
    logic state_we_out, state_re_out, data_we_out, data_re_out;
    logic [31:0] addr_out;
    logic [5:0] state_wr;
    logic [127:0] data_wr;
    logic [5:0] ram_state_in;
    logic [127:0] ram_data_in;

    always #5 clk = ~clk;

    memory_ram_access_ctrl #(.ST_W(6), .DATA_W(128), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .loc_req(loc_req), .loc_op(loc_op), .loc_addr(loc_addr), .loc_state(loc_state), .loc_data(loc_data),
        .loc_gnt(loc_gnt), .loc_done(loc_done),
        .ic_req(ic_req), .ic_op(ic_op), .ic_addr(ic_addr), .ic_state(ic_state), .ic_data(ic_data),
        .ic_gnt(ic_gnt), .ic_done(ic_done),
        .rsp_state(rsp_state), .rsp_data(rsp_data),
        .state_we_out(state_we_out), .state_re_out(state_re_out),
        .data_we_out(data_we_out), .data_re_out(data_re_out),
        .addr_out(addr_out), .state_wr(state_wr), .data_wr(data_wr),
        .ram_state_in(ram_state_in), .ram_data_in(ram_data_in)
    );

    // Synchronous-read RAM pair, 128 lines indexed by addr[10:4]
    logic [5:0]   ram_st [128];
    logic [127:0] ram_dt [128];
    always @(posedge clk) begin
        if (state_re_out) ram_state_in <= ram_st[addr_out[10:4]];
        if (data_re_out)  ram_data_in  <= ram_dt[addr_out[10:4]];
        if (state_we_out) ram_st[addr_out[10:4]] <= state_wr;
        if (data_we_out)  ram_dt[addr_out[10:4]] <= data_wr;
    end

    // Reference model
    logic [5:0]   ref_st [128];
    logic [127:0] ref_dt [128];
    bit           ref_ptr;      // 1: ic wins a tie
    logic [5:0]   last_st;
    logic [127:0] last_dt;
    bit           rsp_known;
    int total, bad;

    bit           tx_en   [2];  // index 0 = loc, 1 = ic
    logic [1:0]   tx_op   [2];
    logic [31:0]  tx_addr [2];
    logic [5:0]   tx_st   [2];
    logic [127:0] tx_dt   [2];

    function automatic int lat_of(input logic [1:0] op);
        case (op)
            2'b00:        return 3;
            2'b01, 2'b10: return 2;
            default:      return RMW_ON ? 4 : 3;
        endcase
    endfunction

    function automatic bit is_read(input logic [1:0] op);
        return (op == 2'b00) || (op == 2'b11);
    endfunction

    function automatic logic [127:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic drive_side(input int s, input logic req, input logic [1:0] op, input logic [31:0] a,
                              input logic [5:0] st, input logic [127:0] dt);
        if (s == 0) begin
            loc_req = req; loc_op = op; loc_addr = a; loc_state = st; loc_data = dt;
        end else begin
            ic_req = req; ic_op = op; ic_addr = a; ic_state = st; ic_data = dt;
        end
    endtask

    task automatic set_tx(input int s, input logic [1:0] op, input logic [31:0] a,
                          input logic [5:0] st, input logic [127:0] dt);
        tx_en[s] = 1'b1; tx_op[s] = op; tx_addr[s] = a; tx_st[s] = st; tx_dt[s] = dt;
    endtask

    // Runs up to one transaction per side; checks grants, strobes, done timing and responses every cycle.
    task automatic run_txns();
        int gcyc[2];
        int lat[2];
        bit granted[2];
        bit finished[2];
        logic [5:0]   exp_st[2];
        logic [127:0] exp_dt[2];
        bit exp_known[2];
        int next_free, act, cyc, off, w;
        bit p0, p1, d, exp_d;
        logic [3:0] exp_stb, got_stb;
        logic [1:0] exp_g, op;
        logic [6:0] idx;
        next_free = 0; act = -1; cyc = 0;
        for (int s = 0; s < 2; s++) begin
            granted[s] = 1'b0; finished[s] = !tx_en[s]; gcyc[s] = 0; lat[s] = 0;
            exp_known[s] = 1'b0; exp_st[s] = '0; exp_dt[s] = '0;
        end
        @(negedge clk);
        for (int s = 0; s < 2; s++)
            drive_side(s, tx_en[s], tx_op[s], tx_addr[s], tx_st[s], tx_dt[s]);
        while (!(finished[0] && finished[1]) && cyc < 40) begin
            #1;
            exp_stb = 4'b0;
            if (act >= 0) begin
                off = cyc - gcyc[act];
                op  = tx_op[act];
                exp_stb[0] = is_read(op) && off == 1;
                exp_stb[1] = is_read(op) && off == 1;
                exp_stb[2] = ((op == 2'b01 || op == 2'b10) && off == 1) || (RMW_ON && op == 2'b11 && off == 3);
                exp_stb[3] = (op == 2'b10) && off == 1;
            end
            got_stb = {data_we_out, state_we_out, data_re_out, state_re_out};
            total++;
            if (got_stb !== exp_stb) begin
                bad++; $display("FAIL strobes cyc=%0d got=%b exp=%b", cyc, got_stb, exp_stb);
            end
            if (exp_stb != 4'b0) begin
                total++;
                if (addr_out !== tx_addr[act]) begin
                    bad++; $display("FAIL addr_out got=%h exp=%h", addr_out, tx_addr[act]);
                end
            end
            if (exp_stb[2]) begin
                total++;
                if (state_wr !== tx_st[act]) begin
                    bad++; $display("FAIL state_wr got=%h exp=%h", state_wr, tx_st[act]);
                end
            end
            if (exp_stb[3]) begin
                total++;
                if (data_wr !== tx_dt[act]) begin
                    bad++; $display("FAIL data_wr got=%h exp=%h", data_wr, tx_dt[act]);
                end
            end
            for (int s = 0; s < 2; s++) begin
                d = (s == 0) ? loc_done : ic_done;
                exp_d = granted[s] && !finished[s] && (cyc == gcyc[s] + lat[s]);
                total++;
                if (d !== exp_d) begin
                    bad++; $display("FAIL done side=%0d cyc=%0d got=%b exp=%b", s, cyc, d, exp_d);
                end
                if (exp_d) begin
                    finished[s] = 1'b1;
                    if (exp_known[s]) begin
                        total++;
                        if ({rsp_state, rsp_data} !== {exp_st[s], exp_dt[s]}) begin
                            bad++;
                            $display("FAIL rsp side=%0d got=%h/%h exp=%h/%h", s, rsp_state, rsp_data, exp_st[s], exp_dt[s]);
                        end
                    end
                end
            end
            w = -1; p0 = 1'b0; p1 = 1'b0;
            if (cyc == next_free) begin
                p0 = tx_en[0] && !granted[0];
                p1 = tx_en[1] && !granted[1];
                if (p0 && p1) w = ref_ptr ? 1 : 0;
                else if (p0)  w = 0;
                else if (p1)  w = 1;
            end
            exp_g = (w == 0) ? 2'b01 : (w == 1) ? 2'b10 : 2'b00;
            total++;
            if ({ic_gnt, loc_gnt} !== exp_g) begin
                bad++; $display("FAIL grant cyc=%0d got ic/loc=%b exp=%b", cyc, {ic_gnt, loc_gnt}, exp_g);
            end
            if (w >= 0) begin
                if (p0 && p1) ref_ptr = (w == 0);
                granted[w] = 1'b1; gcyc[w] = cyc; lat[w] = lat_of(tx_op[w]); act = w;
                next_free = cyc + lat[w];
                idx = tx_addr[w][10:4];
                op  = tx_op[w];
                if (is_read(op)) begin
                    exp_st[w] = ref_st[idx]; exp_dt[w] = ref_dt[idx]; exp_known[w] = 1'b1;
                    last_st = ref_st[idx]; last_dt = ref_dt[idx]; rsp_known = 1'b1;
                end else begin
                    exp_st[w] = last_st; exp_dt[w] = last_dt; exp_known[w] = rsp_known;
                end
                if (op == 2'b01) ref_st[idx] = tx_st[w];
                if (op == 2'b10) begin ref_st[idx] = tx_st[w]; ref_dt[idx] = tx_dt[w]; end
                if (op == 2'b11 && RMW_ON) ref_st[idx] = tx_st[w];
            end
            @(negedge clk);
            cyc++;
            // After a grant the requester lets go; scrambled inputs must not disturb the latched op.
            for (int s = 0; s < 2; s++)
                if (granted[s])
                    drive_side(s, 1'b0, 2'($urandom), $urandom, 6'($urandom), rand_line());
        end
        for (int s = 0; s < 2; s++) tx_en[s] = 1'b0;
        total++;
        if (!(finished[0] && finished[1])) begin
            bad++; $display("FAIL txn_timeout got=%b%b exp=11", finished[1], finished[0]);
        end
    endtask

    task automatic test_reset();
        logic [3:0] stb;
        rst = 1'b1;
        drive_side(0, 1'b1, 2'b00, 32'h30, 6'h0, '0);
        drive_side(1, 1'b1, 2'b00, 32'h30, 6'h0, '0);
        repeat (3) begin
            @(negedge clk); #1;
            stb = {data_we_out, state_we_out, data_re_out, state_re_out};
            total++;
            if ({loc_gnt, ic_gnt, loc_done, ic_done, stb} !== 8'h0) begin
                bad++; $display("FAIL reset_ctl got=%b exp=0", {loc_gnt, ic_gnt, loc_done, ic_done, stb});
            end
            total++;
            if ({rsp_state, rsp_data} !== '0) begin
                bad++; $display("FAIL reset_rsp got=%h/%h exp=0", rsp_state, rsp_data);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        drive_side(0, 1'b0, 2'b00, '0, '0, '0);
        drive_side(1, 1'b0, 2'b00, '0, '0, '0);
        ref_ptr = 1'b1; last_st = '0; last_dt = '0; rsp_known = 1'b1;
    endtask

    // Both sides hold requests continuously: ties must alternate starting with ic.
    task automatic test_rr();
        int gside[4];
        int k, w;
        logic [1:0] exp_g, exp_dn;
        @(negedge clk);
        drive_side(0, 1'b1, 2'b00, 32'h100, 6'h0, '0);
        drive_side(1, 1'b1, 2'b00, 32'h100, 6'h0, '0);
        for (int cyc = 0; cyc <= 12; cyc++) begin
            #1;
            exp_g = 2'b00; exp_dn = 2'b00;
            if (cyc % 3 == 0 && cyc >= 3) exp_dn = (gside[cyc / 3 - 1] == 1) ? 2'b10 : 2'b01;
            if (cyc % 3 == 0 && cyc <= 9) begin
                k = cyc / 3;
                w = ref_ptr ? 1 : 0;
                ref_ptr = (w == 0);
                gside[k] = w;
                exp_g = (w == 1) ? 2'b10 : 2'b01;
            end
            total++;
            if ({ic_gnt, loc_gnt} !== exp_g) begin
                bad++; $display("FAIL rr_grant cyc=%0d got=%b exp=%b", cyc, {ic_gnt, loc_gnt}, exp_g);
            end
            total++;
            if ({ic_done, loc_done} !== exp_dn) begin
                bad++; $display("FAIL rr_done cyc=%0d got=%b exp=%b", cyc, {ic_done, loc_done}, exp_dn);
            end
            @(negedge clk);
            if (cyc == 9) begin
                drive_side(0, 1'b0, 2'b00, '0, '0, '0);
                drive_side(1, 1'b0, 2'b00, '0, '0, '0);
            end
        end
        rsp_known = 1'b0;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 128; i++) begin
            set_tx(i % 2, 2'b10, {$urandom_range(0, 1) == 1 ? 21'h1abcd : 21'h0, 7'(i), 4'($urandom)},
                   6'($urandom), rand_line());
            run_txns();
        end
    endtask

    task automatic test_read();
        set_tx(0, 2'b10, 32'h30, 6'h21, 128'hD0D0_0000_1111_2222_3333_4444_5555_6666);
        run_txns();
        set_tx(0, 2'b00, 32'h30, 6'h3f, '0);
        run_txns();
        total++;
        if ({rsp_state, rsp_data} !== {6'h21, 128'hD0D0_0000_1111_2222_3333_4444_5555_6666}) begin
            bad++; $display("FAIL read_line3 got=%h/%h exp=21/D0", rsp_state, rsp_data);
        end
    endtask

    task automatic test_write_then_read();
        set_tx(1, 2'b10, 32'h7F0, 6'h10, 128'hD1D1_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0123);
        run_txns();
        set_tx(0, 2'b00, 32'h7F0, 6'h00, '0);
        run_txns();
        total++;
        if ({rsp_state, rsp_data} !== {6'h10, 128'hD1D1_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0123}) begin
            bad++; $display("FAIL wr_then_rd got=%h/%h exp=10/D1", rsp_state, rsp_data);
        end
    endtask

    task automatic test_rmw();
        logic [5:0] after;
        set_tx(0, 2'b10, 32'h40, 6'h03, 128'hD2D2_0102_0304_0506_0708_090A_0B0C_0D0E);
        run_txns();
        set_tx(0, 2'b11, 32'h40, 6'h13, 128'hFFFF);
        run_txns();
        total++;
        if (rsp_state !== 6'h03) begin
            bad++; $display("FAIL rmw_old got=%h exp=03", rsp_state);
        end
        set_tx(1, 2'b00, 32'h40, 6'h00, '0);
        run_txns();
        after = RMW_ON ? 6'h13 : 6'h03;
        total++;
        if ({rsp_state, rsp_data} !== {after, 128'hD2D2_0102_0304_0506_0708_090A_0B0C_0D0E}) begin
            bad++; $display("FAIL rmw_after got=%h/%h exp=%h/D2", rsp_state, rsp_data, after);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        drive_side(0, 1'b1, 2'b00, 32'h30, 6'h0, '0);
        #1;
        total++;
        if (loc_gnt !== 1'b1) begin
            bad++; $display("FAIL mid_gnt got=%b exp=1", loc_gnt);
        end
        @(negedge clk);                      // RD
        drive_side(0, 1'b0, 2'b00, '0, '0, '0);
        @(negedge clk);                      // CAP
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if ({data_we_out, state_we_out, data_re_out, state_re_out, loc_done, ic_done} !== 6'b0) begin
            bad++; $display("FAIL mid_ctl got=%b exp=0",
                            {data_we_out, state_we_out, data_re_out, state_re_out, loc_done, ic_done});
        end
        total++;
        if ({rsp_state, rsp_data} !== '0) begin
            bad++; $display("FAIL mid_rsp got=%h/%h exp=0", rsp_state, rsp_data);
        end
        repeat (4) begin
            @(negedge clk); #1;
            total++;
            if ({loc_done, state_we_out, state_re_out} !== 3'b0) begin
                bad++; $display("FAIL mid_quiet got=%b exp=0", {loc_done, state_we_out, state_re_out});
            end
        end
        ref_ptr = 1'b1; last_st = '0; last_dt = '0; rsp_known = 1'b1;
        set_tx(0, 2'b00, 32'h30, 6'h0, '0);
        run_txns();
    endtask

    task automatic test_random();
        int mode;
        logic [31:0] a;
        for (int n = 0; n < 40; n++) begin
            mode = $urandom_range(0, 2);
            for (int s = 0; s < 2; s++) begin
                if (mode == 2 || mode == s) begin
                    a = $urandom;
                    a[10:4] = 7'($urandom_range(0, 7));
                    set_tx(s, 2'($urandom), a, 6'($urandom), rand_line());
                end
            end
            run_txns();
        end
    endtask

    initial begin
        total = 0; bad = 0;
        for (int s = 0; s < 2; s++) tx_en[s] = 1'b0;
        rst = 1'b1;
        drive_side(0, 1'b0, 2'b00, '0, '0, '0);
        drive_side(1, 1'b0, 2'b00, '0, '0, '0);
        test_reset();
        test_rr();
        test_fill();
        test_read();
        test_write_then_read();
        test_rmw();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
